// File: rtl/nn_fixed_pkg.sv
// -----------------------------------------------------------------------------
// nn_fixed_pkg
// Shared Q16.16 fixed-point definitions for the sigmoid forward and backward
// paths.
//   FIXED_1      : 1.0 in Q16.16
//   fixed_t      : 32-bit Q16.16 container
//   fixed_mult_u : unsigned product, >> 16 (truncates toward zero)
//   fixed_mult_s : signed product, >>> 16 (truncates toward -inf)
// -----------------------------------------------------------------------------
package nn_fixed_pkg;

  localparam logic [31:0] FIXED_1 = 32'h0001_0000;

  typedef logic [31:0] fixed_t;

  function automatic fixed_t fixed_mult_u(input fixed_t a, input fixed_t b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    return fixed_t'(p >> 16);
  endfunction

  function automatic fixed_t fixed_mult_s(input fixed_t a, input fixed_t b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return fixed_t'(p >>> 16);
  endfunction

endpackage

// File: rtl/sigmoid_deriv.sv
// -----------------------------------------------------------------------------
// sigmoid_deriv
// Combinational sigmoid derivative from the forward activation:
//   deriv_o = a_c * (1 - a_c), a_c = min(act_i, 1.0), all unsigned Q16.16.
// Ports:
//   act_i   : activation a, unsigned Q16.16
//   deriv_o : a*(1-a), range 0..0x4000
// -----------------------------------------------------------------------------
module sigmoid_deriv
  import nn_fixed_pkg::*;
(
  input  logic [31:0] act_i,
  output logic [31:0] deriv_o
);

  fixed_t act_c;

  // Activations above 1.0 are clamped so (1 - a) can never go negative.
  assign act_c   = (act_i > FIXED_1) ? FIXED_1 : act_i;
  assign deriv_o = fixed_mult_u(act_c, FIXED_1 - act_c);

endmodule

// File: rtl/sigmoid_backprop_unit.sv
// -----------------------------------------------------------------------------
// sigmoid_backprop_unit
// Two-stage streaming backward element: delta = e * a * (1 - a), Q16.16.
// Stage 1 registers the derivative, error and last flag; stage 2 registers
// the signed product. Valid/ready on both sides, no skid buffer.
// Ports:
//   clk, rst                     : clock, async active-high reset
//   in_valid/in_ready            : input handshake
//   in_act, in_err, in_last      : activation (u Q16.16), error (s Q16.16), end of vector
//   out_valid/out_ready          : output handshake
//   out_delta, out_last          : gradient (s Q16.16), end of vector
//   vec_done, vec_count          : pulse + element count when a vector completes
// -----------------------------------------------------------------------------
module sigmoid_backprop_unit
  import nn_fixed_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_act,
  input  logic [31:0]      in_err,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_delta,
  output logic             out_last,
  output logic             vec_done,
  output logic [CNT_W-1:0] vec_count
);

  fixed_t deriv;

  logic       s1_v_q, s1_v_d;
  fixed_t     s1_d_q, s1_d_d;
  fixed_t     s1_e_q, s1_e_d;
  logic       s1_last_q, s1_last_d;

  logic       s2_v_q, s2_v_d;
  fixed_t     s2_delta_q, s2_delta_d;
  logic       s2_last_q, s2_last_d;

  logic [CNT_W-1:0] elem_q, elem_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             done_q, done_d;

  logic s1_adv, s2_adv, out_xfer;

  sigmoid_deriv u_deriv (
    .act_i   (in_act),
    .deriv_o (deriv)
  );

  // A stage may load when it is empty or its contents leave this cycle.
  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign out_xfer = s2_v_q && out_ready;

  assign in_ready  = s1_adv;
  assign out_valid = s2_v_q;
  assign out_delta = s2_delta_q;
  assign out_last  = s2_last_q;
  assign vec_done  = done_q;
  assign vec_count = vcnt_q;

  always_comb begin
    s1_v_d     = s1_v_q;
    s1_d_d     = s1_d_q;
    s1_e_d     = s1_e_q;
    s1_last_d  = s1_last_q;
    s2_v_d     = s2_v_q;
    s2_delta_d = s2_delta_q;
    s2_last_d  = s2_last_q;
    elem_d     = elem_q;
    vcnt_d     = vcnt_q;
    done_d     = 1'b0;

    if (s1_adv) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_d_d    = deriv;
        s1_e_d    = in_err;
        s1_last_d = in_last;
      end
    end

    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        // d <= 0x4000, so the signed product always fits in 32 bits.
        s2_delta_d = fixed_mult_s(s1_e_q, s1_d_q);
        s2_last_d  = s1_last_q;
      end
    end

    if (out_xfer) begin
      if (s2_last_q) begin
        done_d = 1'b1;
        vcnt_d = elem_q + 1'b1;
        elem_d = '0;
      end else begin
        elem_d = elem_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_d_q     <= '0;
      s1_e_q     <= '0;
      s1_last_q  <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_delta_q <= '0;
      s2_last_q  <= 1'b0;
      elem_q     <= '0;
      vcnt_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_d_q     <= s1_d_d;
      s1_e_q     <= s1_e_d;
      s1_last_q  <= s1_last_d;
      s2_v_q     <= s2_v_d;
      s2_delta_q <= s2_delta_d;
      s2_last_q  <= s2_last_d;
      elem_q     <= elem_d;
      vcnt_q     <= vcnt_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_sigmoid_backprop_unit.sv
module tb_sigmoid_backprop_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_act, in_err;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_delta;
  logic        vec_done;
  logic [15:0] vec_count;

  sigmoid_backprop_unit #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .in_err    (in_err),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_delta (out_delta),
    .out_last  (out_last),
    .vec_done  (vec_done),
    .vec_count (vec_count)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  bit     rnd_rdy = 1'b0;

  // in-flight model: expected delta/last and the edge on which each beat was accepted
  logic [31:0] exp_q[$];
  logic        exp_last_q[$];
  longint      acc_q[$];
  logic [31:0] got_q[$];
  logic [15:0] vc_log[$];

  logic [15:0] mdl_cnt = '0;
  logic [15:0] mdl_vc  = '0;
  logic        exp_done = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_delta = '0;
  logic        prev_last  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // delta = e * a_c * (1 - a_c) with floor rounding at each >> 16
  function automatic logic [31:0] mdl(input logic [31:0] a, input logic [31:0] e);
    longint ac, d, p;
    ac = (a > 32'h10000) ? 64'h10000 : 64'(a);
    d  = (ac * (65536 - ac)) >>> 16;
    p  = longint'($signed(e)) * d;
    p  = p >>> 16;
    return p[31:0];
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 2) != 0);
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_last_q.delete();
      acc_q.delete();
      mdl_cnt    = '0;
      mdl_vc     = '0;
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("vec_done", 64'(vec_done), 64'(exp_done));
      chk("vec_count", 64'(vec_count), 64'(mdl_vc));
      exp_done = 1'b0;
      if (vec_done) vc_log.push_back(vec_count);
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0 && acc_q[0] <= cyc - 1));
      chk("in_ready", 64'(in_ready), 64'(!(exp_q.size() == 2 && !out_ready)));
      if (prev_stall) begin
        chk("stall_delta", 64'(out_delta), 64'(prev_delta));
        chk("stall_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        chk("out_delta", 64'(out_delta), 64'(exp_q[0]));
        chk("out_last", 64'(out_last), 64'(exp_last_q[0]));
        got_q.push_back(out_delta);
        if (exp_last_q[0]) begin
          exp_done = 1'b1;
          mdl_vc   = mdl_cnt + 16'd1;
          mdl_cnt  = '0;
        end else begin
          mdl_cnt = mdl_cnt + 16'd1;
        end
        void'(exp_q.pop_front());
        void'(exp_last_q.pop_front());
        void'(acc_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_delta = out_delta;
      prev_last  = out_last;
      if (in_valid && in_ready) begin
        exp_q.push_back(mdl(in_act, in_err));
        exp_last_q.push_back(in_last);
        acc_q.push_back(cyc + 1);
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] e, input logic l);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_act   = a;
    in_err   = e;
    in_last  = l;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [31:0] rand_act();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'h10000;
      2:       return $urandom_range(32'h10001, 32'h1FFFF);
      3:       return $urandom;
      default: return $urandom_range(0, 32'hFFFF);
    endcase
  endfunction

  initial begin
    logic [31:0] lit[6];
    lit = '{32'h4000, 32'hFFFFD000, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
    in_valid  = 1'b0;
    in_act    = '0;
    in_err    = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    chk("model_half", 64'(mdl(32'h8000, 32'h10000)), 64'h4000);
    chk("model_neg", 64'(mdl(32'hC000, 32'hFFFF0000)), 64'hFFFFD000);
    chk("model_floor", 64'(mdl(32'h8000, 32'hFFFFFFFF)), 64'hFFFFFFFF);
    chk("model_clamp", 64'(mdl(32'h18000, 32'h50000)), 64'h0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_vec_count", 64'(vec_count), 64'd0);
    @(posedge clk);
    #1;

    // directed values from the hand-worked cases
    got_q.delete();
    send(32'h8000,  32'h10000,    1'b0);
    send(32'hC000,  32'hFFFF0000, 1'b0);
    send(32'h8000,  32'hFFFFFFFF, 1'b0);
    send(32'h10000, 32'h50000,    1'b0);
    send(32'h18000, 32'h50000,    1'b0);
    send(32'h0,     32'h50000,    1'b1);
    drain();
    chk("dir_count", 64'(got_q.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      if (got_q.size() > i) chk($sformatf("dir_val%0d", i), 64'(got_q[i]), 64'(lit[i]));

    // five beats under random backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 5; i++) send(rand_act(), $urandom, (i == 4));
    drain();
    rnd_rdy   = 1'b0;
    out_ready = 1'b1;

    // 3-beat vector straight into a 2-beat vector
    repeat (2) @(posedge clk);
    #1;
    vc_log.delete();
    for (int i = 0; i < 5; i++) send(rand_act(), $urandom, (i == 2 || i == 4));
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("vec_pulses", 64'(vc_log.size()), 64'd2);
    if (vc_log.size() == 2) begin
      chk("vec_count_a", 64'(vc_log[0]), 64'd3);
      chk("vec_count_b", 64'(vc_log[1]), 64'd2);
    end

    // longer random stream with random gaps, vector ends and backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(rand_act(), $urandom, (i == 79) || ($urandom_range(0, 5) == 0));
    end
    drain();
    rnd_rdy   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // reset with two beats stuck in the pipe
    out_ready = 1'b0;
    send(rand_act(), $urandom, 1'b0);
    send(rand_act(), $urandom, 1'b1);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_vec_count", 64'(vec_count), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    got_q.delete();
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_outputs", 64'(got_q.size()), 64'd0);
    chk("post_rst_vec_count", 64'(vec_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
